adat_tx_scheduler: RTL and testbench
====================================

# adat_tx_scheduler

Frame pacing and buffering controller for the ADAT transmit path. Accepts 8-channel 24-bit sample sets through a valid/ready stream into a small FIFO, launches one ADAT frame per sample period on the downstream frame generator (`start`/`frame_done` handshake), and presents stable audio/user data during each frame. Underruns and late frames are flagged and counted so the system can detect source starvation or a misconfigured clock ratio.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `SAMPLE_RATE`, 48000: frame rate in Hz; `FRAME_CLOCKS = CLK_FREQ / SAMPLE_RATE` (integer division; 2083 at defaults).
- `FIFO_DEPTH`, 4: sample-set FIFO depth; power of two, ≥2.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run frame scheduling.
- `s_valid` in 1: sample set valid.
- `s_ready` out 1: FIFO can accept a sample set.
- `s_audio` in 24×[0:7]: channel samples (unpacked array).
- `s_user` in 4: user bits for this frame.
- `gen_start` out 1: one-cycle frame launch pulse to the generator.
- `gen_audio` out 24×[0:7]: audio presented to the generator.
- `gen_user` out 4: user bits presented to the generator.
- `gen_done` in 1: generator frame-complete pulse.
- `underrun` out 1: one-cycle pulse; tick found FIFO empty.
- `late_frame` out 1: one-cycle pulse; tick arrived while a frame was still in flight.
- `underrun_count` out 16: saturating underrun counter.
- `frame_count` out 32: wrapping count of completed frames.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Tick counter: held at 0 while `enable`=0. While `enable`=1 it counts 0..FRAME_CLOCKS-1 and wraps. A tick occurs when the counter is 0, so the first tick is on the first enabled cycle and later ticks come every FRAME_CLOCKS cycles.
- FIFO: push when `s_valid && s_ready`. `s_ready = (fifo_level < FIFO_DEPTH)`. There is no pass-through when full, even if a pop happens in the same cycle. A simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, WAIT_TICK, ACTIVE.
  - IDLE: `enable`=1 → WAIT_TICK. The tick on that same cycle is honoured.
  - WAIT_TICK, on tick:
    - If the FIFO is non-empty, pop the head into `gen_audio`/`gen_user`.
    - If the FIFO is empty, pulse `underrun`, increment `underrun_count` (saturating at 0xFFFF) and load the underrun data (see Configuration).
    - Assert `gen_start` and go to ACTIVE. A frame launches even on underrun.
  - WAIT_TICK with `enable`=0 → IDLE.
  - ACTIVE:
    - A tick pulses `late_frame`. The tick is dropped, with no pop and no launch.
    - On `gen_done`, increment `frame_count`, then go to WAIT_TICK if `enable`=1, else IDLE.
    - Deasserting `enable` in ACTIVE never aborts a frame.
- `gen_audio`/`gen_user` change only on the launch edge. They hold until the next launch.
- FIFO contents are retained across `enable` toggles.

## Timing
- Reset values:
  - `gen_start`, `underrun`, `late_frame`: 0.
  - `gen_audio`, `gen_user`: 0.
  - `underrun_count`, `frame_count`: 0.
  - `fifo_level`: 0; FIFO empty.
  - `s_ready`: 1.
  - FSM in IDLE; tick counter 0.
- Tick at cycle T in WAIT_TICK: `gen_start`=1 in cycle T+1 only. `gen_audio`/`gen_user` hold the new values from T+1.
- `underrun` is asserted in cycle T+1, coincident with `gen_start`.
- `gen_done` at cycle D: `frame_count` updates at D+1 and the FSM is in WAIT_TICK at D+1. A tick in cycle D itself still counts as late.
- A sample pushed at cycle P is poppable by a tick at P+1 or later.
- Asynchronous reset mid-frame clears all state immediately. The generator is expected to be reset together with this block.

## Configuration
- `ADAT_TX_UNDERRUN_MUTE_EN` defined: on underrun, `gen_audio` and `gen_user` load all zeros (muted frame).
- Undefined: on underrun, `gen_audio`/`gen_user` keep their previous values, so the last sample set is repeated. After reset that is all zeros.

## Test plan
- Reset then enable, push sets with ch0=0x000001..0x000004:
  - `gen_start` pulses at cycles 1, 2084, 4167 and 6250 after enable.
  - `gen_audio[0]` reads 1, 2, 3, 4 in order; `underrun` never fires.
- Enable with the FIFO empty:
  - `underrun` and `gen_start` fire in the same cycle, `underrun_count`=1.
  - `gen_audio` is 0 with the macro defined, or the previous set repeated without it.
- Fill the FIFO to 4 with `s_valid` held:
  - `s_ready`=0 until the next pop.
  - A push coincident with that pop is not accepted; `fifo_level` goes to 3, then 4 on the following push.
- Generator model delays `gen_done` beyond FRAME_CLOCKS:
  - `late_frame` pulses once and no FIFO pop occurs.
  - The next launch follows the first tick after `gen_done`.
- Deassert `enable` mid-frame:
  - `gen_done` is still awaited, `frame_count` increments, the FSM goes to IDLE and no further `gen_start` is issued.
  - Re-enabling launches on the first enabled cycle.
- Assert `rst_n`=0 in ACTIVE with 3 entries queued: all outputs return to their reset values and `fifo_level`=0.

Source files
------------

// File: rtl/adat_tx_scheduler.sv
// Purpose : ADAT transmit frame pacer. Buffers sample sets and launches one generator frame per sample period.
// Latency : a tick in cycle T gives gen_start/underrun and new gen_audio/gen_user in T+1; a pushed set can be popped from the next cycle.
// Backpr. : s_ready drops while the FIFO holds FIFO_DEPTH sets. There is no bypass when full. Late ticks are dropped, never queued.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   enable               run frame scheduling (tick counter is held at 0 while low)
//   s_valid/s_ready      sample-set stream handshake; s_audio[0:7] (24b each), s_user (4b)
//   gen_start            one-cycle frame launch pulse to the frame generator
//   gen_audio, gen_user  data for the frame in flight; these change only on a launch
//   gen_done             generator frame-complete pulse
//   underrun             pulse: the tick found the FIFO empty (coincident with gen_start)
//   late_frame           pulse: a tick arrived while a frame was still in flight
//   underrun_count       saturating 16-bit underrun counter
//   frame_count          wrapping 32-bit completed-frame counter
//   fifo_level           current FIFO occupancy
//
// Build option: define ADAT_TX_UNDERRUN_MUTE_EN to send an all-zero frame on underrun.
// Without it the previous audio/user data is repeated.

module adat_tx_scheduler #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int SAMPLE_RATE = 48000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [23:0]                   s_audio [0:7],
   input  logic [3:0]                    s_user,
   output logic                          gen_start,
   output logic [23:0]                   gen_audio [0:7],
   output logic [3:0]                    gen_user,
   input  logic                          gen_done,
   output logic                          underrun,
   output logic                          late_frame,
   output logic [15:0]                   underrun_count,
   output logic [31:0]                   frame_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int FRAME_CLOCKS = CLK_FREQ / SAMPLE_RATE;
   localparam int CNT_W        = (FRAME_CLOCKS > 1) ? $clog2(FRAME_CLOCKS) : 1;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int LVL_W        = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLOCKS - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   // One buffered sample set: eight channels plus the frame's user bits.
   typedef struct packed {
      logic [7:0][23:0] audio;
      logic [3:0]       user;
   } set_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      ACTIVE
   } state_t;

   state_t            state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   set_t              mem_q [FIFO_DEPTH];
   set_t              mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
   logic [LVL_W-1:0]  level_q,     level_d;
   set_t              gen_q,       gen_d;
   logic              gen_start_q, gen_start_d;
   logic              underrun_q,  underrun_d;
   logic              late_q,      late_d;
   logic [15:0]       under_cnt_q, under_cnt_d;
   logic [31:0]       frame_cnt_q, frame_cnt_d;

   set_t              in_set;
   logic              tick;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              launch;

   // Channel 0 lands in audio[0]; the concatenation lists the MSB (channel 7) first.
   assign in_set = {s_audio[7], s_audio[6], s_audio[5], s_audio[4],
                    s_audio[3], s_audio[2], s_audio[1], s_audio[0], s_user};

   // The counter sits at 0 while disabled, so the first enabled cycle is always a tick.
   assign tick       = enable && (cnt_q == '0);
   assign fifo_empty = (level_q == '0);
   // Readiness depends only on the registered level. A pop in the same cycle does not free the slot early.
   assign s_ready    = (level_q < LVL_FULL);
   assign push       = s_valid && s_ready;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Frame scheduling: launch decision, data capture, pulse generation and counters.
   always_comb begin
      state_d     = state_q;
      gen_d       = gen_q;
      gen_start_d = 1'b0;
      underrun_d  = 1'b0;
      late_d      = 1'b0;
      under_cnt_d = under_cnt_q;
      frame_cnt_d = frame_cnt_q;
      launch      = 1'b0;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            // The tick on the enabling cycle is honoured directly from IDLE.
            if (enable) begin
               if (tick) begin
                  launch = 1'b1;
               end else begin
                  state_d = WAIT_TICK;
               end
            end
         end
         WAIT_TICK: begin
            if (tick) begin
               launch = 1'b1;
            end else if (!enable) begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            // A tick during a frame is reported and then dropped. It never queues a launch.
            if (tick) begin
               late_d = 1'b1;
            end
            if (gen_done) begin
               frame_cnt_d = frame_cnt_q + 32'd1;
               state_d     = enable ? WAIT_TICK : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (launch) begin
         state_d     = ACTIVE;
         gen_start_d = 1'b1;
         if (!fifo_empty) begin
            pop   = 1'b1;
            gen_d = mem_q[rd_ptr_q];
         end else begin
            underrun_d = 1'b1;
            if (under_cnt_q != 16'hFFFF) begin
               under_cnt_d = under_cnt_q + 16'd1;
            end
`ifdef ADAT_TX_UNDERRUN_MUTE_EN
            gen_d = '0;
`else
            // gen_d keeps its value, so the last delivered set is replayed.
            gen_d = gen_q;
`endif
         end
      end
   end

   // Circular FIFO storage and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_set;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         gen_q       <= '0;
         gen_start_q <= 1'b0;
         underrun_q  <= 1'b0;
         late_q      <= 1'b0;
         under_cnt_q <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         gen_q       <= gen_d;
         gen_start_q <= gen_start_d;
         underrun_q  <= underrun_d;
         late_q      <= late_d;
         under_cnt_q <= under_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   genvar g;
   for (g = 0; g < 8; g++) begin : g_audio_out
      assign gen_audio[g] = gen_q.audio[g];
   end

   assign gen_user       = gen_q.user;
   assign gen_start      = gen_start_q;
   assign underrun       = underrun_q;
   assign late_frame     = late_q;
   assign underrun_count = under_cnt_q;
   assign frame_count    = frame_cnt_q;
   assign fifo_level     = level_q;

endmodule

// File: tb/tb_adat_tx_scheduler.sv
// Purpose : self-checking bench for adat_tx_scheduler (directed scenarios plus randomized traffic against a queue model).
// Latency : observes DUT state 1 time unit after each rising clk edge.
// Backpr. : drives s_valid independently of s_ready; the model decides acceptance.

module tb_adat_tx_scheduler;

   localparam int FC    = 100_000_000 / 48000;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [7:0][23:0] a;
      logic [3:0]       u;
   } set_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        s_valid;
   logic        s_ready;
   logic [23:0] s_audio [0:7];
   logic [3:0]  s_user;
   logic        gen_start;
   logic [23:0] gen_audio [0:7];
   logic [3:0]  gen_user;
   logic        gen_done;
   logic        underrun;
   logic        late_frame;
   logic [15:0] underrun_count;
   logic [31:0] frame_count;
   logic [2:0]  fifo_level;

   always #5 clk = ~clk;

   adat_tx_scheduler #(
      .CLK_FREQ   (100_000_000),
      .SAMPLE_RATE(48000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_audio       (s_audio),
      .s_user        (s_user),
      .gen_start     (gen_start),
      .gen_audio     (gen_audio),
      .gen_user      (gen_user),
      .gen_done      (gen_done),
      .underrun      (underrun),
      .late_frame    (late_frame),
      .underrun_count(underrun_count),
      .frame_count   (frame_count),
      .fifo_level    (fifo_level)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Frames are launched on ticks (every FC enabled cycles, starting on the first one) when no frame is in flight.
   set_t        mq[$];
   set_t        m_gen;
   int          m_phase;
   bit          m_busy;
   logic [15:0] m_under;
   logic [31:0] m_frames;
   bit          m_start, m_up, m_late;

   function automatic void model_reset();
      mq.delete();
      m_gen    = '0;
      m_phase  = 0;
      m_busy   = 0;
      m_under  = '0;
      m_frames = '0;
      m_start  = 0;
      m_up     = 0;
      m_late   = 0;
   endfunction

   function automatic void model_cycle(bit en, bit valid, set_t din, bit done);
      bit tick;
      int n;
      tick    = en && ((m_phase % FC) == 0);
      n       = mq.size();
      m_start = tick && !m_busy;
      m_late  = tick && m_busy;
      m_up    = m_start && (n == 0);
      if (m_start) begin
         if (n > 0) begin
            m_gen = mq.pop_front();
         end else begin
            if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
`ifdef ADAT_TX_UNDERRUN_MUTE_EN
            m_gen = '0;
`endif
         end
      end
      if (m_busy && done) begin
         m_frames = m_frames + 32'd1;
         m_busy   = 0;
      end
      if (m_start) m_busy = 1;
      if (valid && (n < DEPTH)) mq.push_back(din);
      m_phase = en ? m_phase + 1 : 0;
   endfunction

   function automatic logic [255:0] mk_obs(logic st, logic un, logic lt, logic rdy, logic [2:0] lvl,
                                           logic [15:0] uc, logic [31:0] fcnt, set_t gs);
      return {5'b0, st, un, lt, rdy, lvl, uc, fcnt, gs};
   endfunction

   function automatic logic [255:0] dut_obs();
      set_t gs;
      gs = {gen_audio[7], gen_audio[6], gen_audio[5], gen_audio[4],
            gen_audio[3], gen_audio[2], gen_audio[1], gen_audio[0], gen_user};
      return mk_obs(gen_start, underrun, late_frame, s_ready, fifo_level, underrun_count, frame_count, gs);
   endfunction

   // ---------------- stepping and generator model ----------------
   int cyc;
   int g_cnt;
   int gen_lo, gen_hi;
   int done_cyc;

   task automatic rand_set();
      for (int i = 0; i < 8; i++) s_audio[i] = 24'($urandom);
      s_user = 4'($urandom);
   endtask

   task automatic step();
      set_t din;
      bit   en_i, v_i, d_i;
      din  = {s_audio[7], s_audio[6], s_audio[5], s_audio[4],
              s_audio[3], s_audio[2], s_audio[1], s_audio[0], s_user};
      en_i = enable;
      v_i  = s_valid;
      d_i  = gen_done;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         model_reset();
      end else begin
         model_cycle(en_i, v_i, din, d_i);
         chk("model", dut_obs(),
             mk_obs(m_start, m_up, m_late, (mq.size() < DEPTH), 3'(mq.size()), m_under, m_frames, m_gen));
      end
      // Generator: gen_done arrives a random number of cycles after each launch.
      if (!rst_n)           g_cnt = 0;
      else if (gen_start)   g_cnt = $urandom_range(gen_hi, gen_lo);
      else if (g_cnt > 0)   g_cnt--;
      gen_done = (g_cnt == 1);
      if (gen_done) done_cyc = cyc + 1;
   endtask

   task automatic wait_start(input int budget, output bit found);
      found = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (gen_start) begin
            found = 1;
            break;
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   int          nst, nun, nlate, leak, moved, lv;
   int          st_cyc [4];
   logic [23:0] st_a0 [4];
   logic [31:0] fc0;
   logic [23:0] exp_a0;
   bit          found;

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      s_valid  = 1'b0;
      s_user   = '0;
      gen_done = 1'b0;
      for (int i = 0; i < 8; i++) s_audio[i] = '0;
      gen_lo   = 10;
      gen_hi   = 1800;
      g_cnt    = 0;
      cyc      = 0;
      done_cyc = 0;
      model_reset();

      repeat (3) step();
      chk("reset_state", dut_obs(), mk_obs(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 32'd0, '0));
      rst_n = 1'b1;
      repeat (2) step();

      // Four sets with ch0 = 1..4 queued before scheduling starts.
      for (int k = 1; k <= 4; k++) begin
         rand_set();
         s_audio[0] = 24'(k);
         s_valid    = 1'b1;
         step();
      end
      s_valid = 1'b0;
      chk("fifo_full_before_enable", 256'({fifo_level, s_ready}), 256'({3'd4, 1'b0}));

      enable = 1'b1;
      cyc    = 0;
      nst    = 0;
      nun    = 0;
      while (cyc < 4 * FC - 10) begin
         step();
         if (gen_start) begin
            if (nst < 4) begin
               st_cyc[nst] = cyc;
               st_a0[nst]  = gen_audio[0];
            end
            nst++;
         end
         if (underrun) nun++;
      end
      chk("launch_count", 256'(nst), 256'(4));
      for (int k = 0; k < 4; k++) begin
         chk("launch_cycle", 256'(st_cyc[k]), 256'(k * FC + 1));
         chk("launch_audio0", 256'(st_a0[k]), 256'(k + 1));
      end
      chk("no_underrun_while_fed", 256'(nun), 256'(0));

      // Next tick finds the FIFO empty.
      wait_start(2 * FC, found);
      chk("underrun_launch_found", 256'(found), 256'(1));
      chk("underrun_cycle", 256'(cyc), 256'(4 * FC + 1));
      chk("underrun_pulse", 256'(underrun), 256'(1));
      chk("underrun_count", 256'(underrun_count), 256'(1));
`ifdef ADAT_TX_UNDERRUN_MUTE_EN
      exp_a0 = 24'd0;
`else
      exp_a0 = 24'd4;
`endif
      chk("underrun_audio0", 256'(gen_audio[0]), 256'(exp_a0));

      // Fill with s_valid held; the push coinciding with the pop must be refused.
      s_valid = 1'b1;
      repeat (6) begin
         rand_set();
         step();
      end
      chk("fill_level", 256'(fifo_level), 256'(4));
      chk("fill_ready_low", 256'(s_ready), 256'(0));
      leak  = 0;
      found = 0;
      for (int i = 0; i < 2 * FC; i++) begin
         rand_set();
         step();
         if (gen_start) begin
            found = 1;
            break;
         end
         if (s_ready) leak++;
      end
      chk("fill_pop_found", 256'(found), 256'(1));
      chk("ready_low_until_pop", 256'(leak), 256'(0));
      chk("pop_refuses_push", 256'(fifo_level), 256'(3));
      rand_set();
      step();
      chk("push_after_pop", 256'(fifo_level), 256'(4));
      s_valid = 1'b0;

      // Generator slower than a frame period.
      gen_lo = FC + 300;
      gen_hi = FC + 300;
      wait_start(2 * FC, found);
      chk("slow_launch_found", 256'(found), 256'(1));
      lv     = int'(fifo_level);
      gen_lo = 10;
      gen_hi = 500;
      nlate  = 0;
      moved  = 0;
      found  = 0;
      for (int i = 0; i < 3 * FC; i++) begin
         step();
         if (late_frame) nlate++;
         if (gen_start) begin
            found = 1;
            break;
         end
         if (int'(fifo_level) != lv) moved++;
      end
      chk("relaunch_found", 256'(found), 256'(1));
      chk("late_pulses", 256'(nlate), 256'(1));
      chk("late_no_pop", 256'(moved), 256'(0));
      chk("relaunch_cycle", 256'(cyc), 256'(((done_cyc / FC) + 1) * FC + 1));

      // Disable mid-frame: the frame still completes, then no more launches.
      enable = 1'b0;
      fc0    = frame_count;
      for (int i = 0; i < 2 * FC; i++) begin
         step();
         if (frame_count != fc0) break;
      end
      chk("frame_done_after_disable", 256'(frame_count), 256'(fc0 + 32'd1));
      nst = 0;
      repeat (2 * FC + 10) begin
         step();
         if (gen_start) nst++;
      end
      chk("no_launch_while_disabled", 256'(nst), 256'(0));
      enable = 1'b1;
      cyc    = 0;
      step();
      chk("reenable_launch", 256'(gen_start), 256'(1));

      // Queue three sets, then reset in the middle of the frame.
      for (int i = 0; i < 10; i++) begin
         if (mq.size() >= 3) break;
         rand_set();
         s_valid = 1'b1;
         step();
      end
      s_valid = 1'b0;
      chk("queued_before_reset", 256'(fifo_level), 256'(3));
      rst_n    = 1'b0;
      gen_done = 1'b0;
      #1;
      chk("reset_midframe", dut_obs(), mk_obs(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 32'd0, '0));
      enable = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();

      // Randomized traffic: sparse valids, occasional enable toggles, generator sometimes late.
      gen_lo = 1;
      gen_hi = FC + 400;
      enable = 1'b1;
      repeat (3 * FC) begin
         rand_set();
         s_valid = ($urandom_range(3) == 0);
         if ($urandom_range(999) == 0) enable = ~enable;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
